cgra_mp_ram: RTL and testbench
==============================

# cgra_mp_ram

Parametrised multi-port word memory serving the CGRA memory units (`mem_N_mem_unit_*_to_ram`) in simulation and FPGA-prototype builds. It generalises the fixed 4-port, 1024-word, 1-cycle RAM model with four additions: configurable port count, depth and read latency; deterministic write-collision resolution with reporting; out-of-range detection; and a host load/dump port plus a hardware clear sequence, so benches no longer preload storage from `initial` blocks. It sits between `cgra_U0` memory ports and the bench, clocked by the gated CGRA clock.

## Interface
Parameters:
- NUM_PORTS, 4, number of CGRA memory ports (1..8)
- DATA_W, 32, word width
- ADDR_W, 32, byte-address width on CGRA ports
- DEPTH, 1024, words of storage (power of two)
- READ_LAT, 1, read latency in cycles (1..4)
- WRITE_FIRST, 0, 0 = read returns old data on same-cycle write; 1 = returns the winning new data
- CLEAR_ON_RESET, 1, 1 = zero all storage after reset

Ports:
- clock  in  1  single clock, rising edge
- sync_reset  in  1  synchronous, active-high reset
- addr  in  NUM_PORTS*ADDR_W  per-port byte address; port p occupies slice p
- data_in  in  NUM_PORTS*DATA_W  per-port write data
- w_rq  in  NUM_PORTS  per-port write request
- data_out  out  NUM_PORTS*DATA_W  per-port read data
- host_addr  in  $clog2(DEPTH)  host word index
- host_wdata  in  DATA_W  host write data
- host_we  in  1  host write enable
- host_rdata  out  DATA_W  host read data, 1-cycle latency
- busy  out  1  clear sequence in progress
- collision  out  NUM_PORTS  port p's write lost arbitration, registered
- oob  out  NUM_PORTS  port p's address out of range, registered

## Operation
- Word index = addr >> 2; low two bits are ignored. Index >= DEPTH is out of range: the write is dropped, read data is 0, and oob[p] is set.
- Every port reads every cycle; there is no read enable.
- Write arbitration on the same word in one cycle: the highest port index wins. Every losing port with w_rq set gets collision[p]=1. Any port write beats a host write to the same word. A host loss is silent.
- Read-during-write on the same word: WRITE_FIRST=0 returns pre-write data; WRITE_FIRST=1 returns the winning write data.
- FSM states: CLEAR, RUN.
  - sync_reset forces CLEAR (if CLEAR_ON_RESET) and zeroes the clear counter; otherwise it forces RUN.
  - CLEAR writes 0 to word counter each cycle. At DEPTH-1 it moves to RUN.
  - During CLEAR: port and host writes are ignored, data_out and host_rdata read 0, and collision and oob stay 0.
  - RUN is held until the next reset.
- Reset mid-CLEAR restarts the counter at 0. Reset never clears storage directly; clearing happens only through CLEAR.

## Timing
- Reset values:
  - data_out = 0 (all pipeline stages), host_rdata = 0, collision = 0, oob = 0.
  - busy = CLEAR_ON_RESET in the cycle after reset is sampled.
- Port read: address sampled at edge k; data_out valid after edge k+READ_LAT-1+1, i.e. READ_LAT edges later. READ_LAT=1 is bit-identical to the legacy model.
- Write commits at the sampling edge; it is visible to reads sampled at the next edge.
- collision and oob are single-cycle pulses one edge after the offending request, independent of READ_LAT.
- CLEAR lasts exactly DEPTH cycles; busy falls on the edge that writes word DEPTH-1.

## Structure
- Package cgra_mem_pkg holds:
  - the state enum (CLEAR, RUN);
  - a word_index function (addr >> 2, range check);
  - READ_LAT bounds.
- Sub-module cgra_rd_pipe: a READ_LAT-deep, DATA_W-wide delay line with synchronous reset to 0. One instance per port.
- Arbitration is a combinational per-word priority loop in the top level.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=1024 -> busy high for 1024 cycles; afterwards every host read of indices 0..1023 returns 0.
- Port 0 writes 0x00010000 at byte 0xA00, then reads it, with READ_LAT=3 -> data_out[0] = 0x00010000 exactly 3 edges after the read address.
- Ports 1 and 3 write 0x11 and 0x33 to byte 0x40 in the same cycle -> word 0x10 = 0x33; collision = 4'b0010 for one cycle.
- Port 2 reads and writes 0xBEEF to word 5 (old value 0x7) in the same cycle -> data_out[2] = 0x7 with WRITE_FIRST=0, 0xBEEF with WRITE_FIRST=1.
- Port 0 accesses byte 0x1000 with DEPTH=1024 -> oob[0] pulses; data_out[0] = 0; storage is unchanged.
- sync_reset asserted at clear cycle 500 -> counter restarts; busy stays high for a further 1024 cycles.

Source files
------------

// File: rtl/cgra_mem_pkg.sv
// -----------------------------------------------------------------------------
// cgra_mem_pkg
// Shared types and helpers for the CGRA multi-port word memory.
//   mem_state_e    : controller states (CLEAR sweeps storage to zero, RUN serves
//                    the ports)
//   READ_LAT_MIN/MAX : supported range of the port read latency
//   word_index     : byte address -> word index (low two bits dropped)
//   word_in_range  : word index check against the storage depth
// -----------------------------------------------------------------------------
package cgra_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  function automatic logic word_in_range(input logic [63:0] word,
                                         input int unsigned depth);
    return word < 64'(depth);
  endfunction

endpackage

// File: rtl/cgra_mp_ram_if.sv
// -----------------------------------------------------------------------------
// cgra_mp_ram_if
// Bundle of the per-port CGRA memory bus. Port p occupies slice p of every
// vector.
//   addr      : byte address per port
//   data_in   : write data per port
//   w_rq      : write request per port
//   data_out  : read data per port (READ_LAT cycles after the address)
//   collision : port lost write arbitration (registered pulse)
//   oob       : port address out of range (registered pulse)
// master = CGRA / bench side, slave = memory side.
// -----------------------------------------------------------------------------
interface cgra_mp_ram_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
);

  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] data_in;
  logic [NUM_PORTS-1:0]        w_rq;
  logic [NUM_PORTS*DATA_W-1:0] data_out;
  logic [NUM_PORTS-1:0]        collision;
  logic [NUM_PORTS-1:0]        oob;

  modport master (
    output addr, data_in, w_rq,
    input  data_out, collision, oob
  );

  modport slave (
    input  addr, data_in, w_rq,
    output data_out, collision, oob
  );

endinterface

// File: rtl/cgra_rd_pipe.sv
// -----------------------------------------------------------------------------
// cgra_rd_pipe
// LAT-deep, DATA_W-wide delay line used to stretch the port read latency.
//   clock      : rising-edge clock
//   sync_reset : synchronous active-high reset, clears every stage to 0
//   d          : data entering the pipe (sampled every edge)
//   q          : d delayed by LAT edges
// -----------------------------------------------------------------------------
module cgra_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clock,
  input  logic              sync_reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] stage_q [LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's value from before the edge.
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[LAT-1];

endmodule

// File: rtl/cgra_mp_ram.sv
// -----------------------------------------------------------------------------
// cgra_mp_ram
// Multi-port word memory for the CGRA memory units.
//   clock      : rising-edge clock (gated CGRA clock)
//   sync_reset : synchronous active-high reset
//   bus        : per-port address / write data / write request in,
//                read data / collision / out-of-range flags out
//   host_addr  : host word index
//   host_wdata : host write data
//   host_we    : host write enable (loses silently to any port write)
//   host_rdata : host read data, one cycle after host_addr
//   busy       : storage clear sweep in progress
// Same-word port writes: highest port index wins, losers flag collision.
// Word index >= DEPTH: write dropped, read returns 0, oob flagged.
// -----------------------------------------------------------------------------
module cgra_mp_ram
  import cgra_mem_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int READ_LAT       = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clock,
  input  logic                     sync_reset,
  cgra_mp_ram_if.slave             bus,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [DATA_W-1:0]        host_wdata,
  input  logic                     host_we,
  output logic [DATA_W-1:0]        host_rdata,
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT   = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                         (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] word_t;

  mem_state_e state_q, state_d;
  idx_t       clr_cnt_q, clr_cnt_d;
  logic       run;

  // NOTE: the storage array has no reset; zeroing it is the job of the CLEAR
  // sweep, which keeps it mappable onto block RAM.
  word_t mem [DEPTH];

  logic [63:0]          port_word  [NUM_PORTS];
  idx_t                 port_idx   [NUM_PORTS];
  word_t                port_wdata [NUM_PORTS];
  word_t                port_rd    [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_ok, port_win, port_lose;
  logic                 host_win;
  logic [NUM_PORTS-1:0] collision_q, oob_q;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + idx_t'(1);
        if (clr_cnt_q == idx_t'(DEPTH - 1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign busy = (state_q == CLEAR);
  assign run  = (state_q == RUN) && !sync_reset;

  // ---------------------------------------------------------------- decode
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_word[p] = word_index(64'(bus.addr[p*ADDR_W +: ADDR_W]));
      port_idx[p]  = port_word[p][IDX_W-1:0];
      port_ok[p]   = word_in_range(port_word[p], DEPTH);
    end
  end

  // ---------------------------------------------------------- arbitration
  // A port write survives only if no higher-index port writes the same word.
  always_comb begin
    port_win  = '0;
    port_lose = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (run && bus.w_rq[p] && port_ok[p]) begin
        port_win[p] = 1'b1;
        for (int q = p + 1; q < NUM_PORTS; q++) begin
          if (bus.w_rq[q] && port_ok[q] && (port_idx[q] == port_idx[p]))
            port_win[p] = 1'b0;
        end
        port_lose[p] = ~port_win[p];
      end
    end
    host_win = run && host_we;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_win[p] && (port_idx[p] == host_addr)) host_win = 1'b0;
    end
  end

  // ---------------------------------------------------------- read mux
  // Winners have distinct words, so at most one forwarding source matches.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_rd[p] = '0;
      if (run && port_ok[p]) begin
        port_rd[p] = mem[port_idx[p]];
        if (WRITE_FIRST != 0) begin
          if (host_win && (host_addr == port_idx[p])) port_rd[p] = host_wdata;
          for (int q = 0; q < NUM_PORTS; q++) begin
            if (port_win[q] && (port_idx[q] == port_idx[p]))
              port_rd[p] = port_wdata[q];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------- storage
  always_ff @(posedge clock) begin
    if (!sync_reset && (state_q == CLEAR)) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (host_win) mem[host_addr] <= host_wdata;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_win[p]) mem[port_idx[p]] <= port_wdata[p];
      end
    end
  end

  // ---------------------------------------------------------- flags / host
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      collision_q <= '0;
      oob_q       <= '0;
      host_rdata  <= '0;
    end else begin
      collision_q <= port_lose;
      oob_q       <= run ? ~port_ok : '0;
      host_rdata  <= (state_q == RUN) ? mem[host_addr] : '0;
    end
  end

  assign bus.collision = collision_q;
  assign bus.oob       = oob_q;

  // ---------------------------------------------------------- read pipes
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    word_t rd_q;

    cgra_rd_pipe #(
      .DATA_W (DATA_W),
      .LAT    (LAT)
    ) u_rd_pipe (
      .clock      (clock),
      .sync_reset (sync_reset),
      .d          (port_rd[p]),
      .q          (rd_q)
    );

    assign bus.data_out[p*DATA_W +: DATA_W] = rd_q;
    assign port_wdata[p] = bus.data_in[p*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_cgra_mp_ram.sv
// -----------------------------------------------------------------------------
// tb_cgra_mp_ram
// Directed bench for cgra_mp_ram. Two instances share the stimulus:
//   u_ram_a : READ_LAT=3, WRITE_FIRST=0
//   u_ram_b : READ_LAT=1, WRITE_FIRST=1
// Inputs change and outputs are sampled 2 time units after each rising edge.
// -----------------------------------------------------------------------------
module tb_cgra_mp_ram;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        sync_reset;
  logic [9:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_we;
  logic [31:0] host_rdata_a, host_rdata_b;
  logic        busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cgra_mp_ram_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus_a ();
  cgra_mp_ram_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus_b ();

  cgra_mp_ram #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .READ_LAT(3), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
  ) u_ram_a (
    .clock      (clock),
    .sync_reset (sync_reset),
    .bus        (bus_a),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_rdata (host_rdata_a),
    .busy       (busy_a)
  );

  cgra_mp_ram #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .READ_LAT(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
  ) u_ram_b (
    .clock      (clock),
    .sync_reset (sync_reset),
    .bus        (bus_b),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_rdata (host_rdata_b),
    .busy       (busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_port(input int p, input logic [31:0] a,
                          input logic [31:0] d, input logic wr);
    bus_a.addr[p*AW +: AW]    = a;
    bus_b.addr[p*AW +: AW]    = a;
    bus_a.data_in[p*DW +: DW] = d;
    bus_b.data_in[p*DW +: DW] = d;
    bus_a.w_rq[p]             = wr;
    bus_b.w_rq[p]             = wr;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int nz;

    sync_reset    = 1'b1;
    host_addr     = '0;
    host_wdata    = '0;
    host_we       = 1'b0;
    bus_a.addr    = '0;
    bus_b.addr    = '0;
    bus_a.data_in = '0;
    bus_b.data_in = '0;
    bus_a.w_rq    = '0;
    bus_b.w_rq    = '0;

    // Reset state
    tick();
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_b", busy_b, 1);
    check("rst_dout_lo", bus_a.data_out[63:0], 0);
    check("rst_dout_hi", bus_a.data_out[127:64], 0);
    check("rst_host_rdata", host_rdata_a, 0);
    check("rst_collision", bus_a.collision, 0);
    check("rst_oob", bus_a.oob, 0);
    sync_reset = 1'b0;

    // Clear sweep: count busy cycles, poke writes and an oob address mid-sweep
    n = 0;
    while (busy_a && n < 2000) begin
      if (n == 10) begin
        host_we = 1'b1; host_addr = 10'd3; host_wdata = 32'hDEAD;
        set_port(0, 32'h14, 32'h55, 1'b1);
        set_port(1, 32'h1000, 32'h0, 1'b0);
      end
      if (n == 11) begin
        check("clear_oob_quiet", bus_a.oob, 0);
        check("clear_dout_b", bus_b.data_out[31:0], 0);
        host_we = 1'b0;
        set_port(0, 32'h0, 32'h0, 1'b0);
        set_port(1, 32'h0, 32'h0, 1'b0);
      end
      tick();
      n++;
    end
    check("clear_cycles", n, 1024);
    check("clear_done_b", busy_b, 0);

    // Every word reads back zero after the sweep
    nz = 0;
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = 10'(i);
      tick();
      if (host_rdata_a !== 32'h0 || host_rdata_b !== 32'h0) nz++;
    end
    check("clear_all_zero", nz, 0);

    // Host load word 5 = 0x7
    host_we = 1'b1; host_addr = 10'd5; host_wdata = 32'h7;
    tick();
    host_we = 1'b0;
    tick();
    check("host_rd_a", host_rdata_a, 32'h7);
    check("host_rd_b", host_rdata_b, 32'h7);

    // Port 0 write 0x00010000 at byte 0xA00, then read with latency 3
    set_port(0, 32'hA00, 32'h0001_0000, 1'b1);
    tick();
    check("wf1_fwd_p0", bus_b.data_out[31:0], 32'h0001_0000);
    set_port(0, 32'hA00, 32'h0, 1'b0);
    tick();
    tick();
    check("lat3_edge2", bus_a.data_out[31:0], 32'h0);
    tick();
    check("lat3_edge3", bus_a.data_out[31:0], 32'h0001_0000);
    check("lat1_stored", bus_b.data_out[31:0], 32'h0001_0000);

    // Ports 1 and 3 collide on byte 0x40; host also targets word 0x10
    set_port(1, 32'h40, 32'h11, 1'b1);
    set_port(3, 32'h40, 32'h33, 1'b1);
    host_we = 1'b1; host_addr = 10'h10; host_wdata = 32'h99;
    tick();
    check("coll_a", bus_a.collision, 4'b0010);
    check("coll_b", bus_b.collision, 4'b0010);
    check("coll_fwd_p1_b", bus_b.data_out[63:32], 32'h33);
    set_port(1, 32'h0, 32'h0, 1'b0);
    set_port(3, 32'h0, 32'h0, 1'b0);
    host_we = 1'b0;
    tick();
    check("coll_pulse_end", bus_a.collision, 0);
    check("coll_word_a", host_rdata_a, 32'h33);
    check("coll_word_b", host_rdata_b, 32'h33);

    // Port 2 read-during-write on word 5 (old value 0x7)
    set_port(2, 32'h14, 32'hBEEF, 1'b1);
    tick();
    check("rdw_wf1", bus_b.data_out[95:64], 32'hBEEF);
    set_port(2, 32'h14, 32'h0, 1'b0);
    tick();
    tick();
    check("rdw_wf0", bus_a.data_out[95:64], 32'h7);
    tick();
    check("rdw_wf0_next", bus_a.data_out[95:64], 32'hBEEF);

    // Port 0 out-of-range access at byte 0x1000
    set_port(0, 32'h1000, 32'hCAFE, 1'b1);
    tick();
    check("oob_a", bus_a.oob, 4'b0001);
    check("oob_b", bus_b.oob, 4'b0001);
    check("oob_dout_b", bus_b.data_out[31:0], 32'h0);
    set_port(0, 32'hA00, 32'h0, 1'b0);
    tick();
    check("oob_pulse_end", bus_a.oob, 0);
    check("oob_after_b", bus_b.data_out[31:0], 32'h0001_0000);
    tick();
    check("oob_dout_a", bus_a.data_out[31:0], 32'h0);
    tick();
    check("oob_after_a", bus_a.data_out[31:0], 32'h0001_0000);
    host_addr = 10'd0;
    tick();
    check("oob_no_write", host_rdata_a, 32'h0);

    // Reset in the middle of a clear sweep restarts it
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    check("rst2_busy", busy_a, 1);
    repeat (500) tick();
    check("mid_clear_busy", busy_a, 1);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    n = 0;
    while (busy_a && n < 2000) begin
      tick();
      n++;
    end
    check("restart_cycles", n, 1024);
    host_addr = 10'h10;
    tick();
    check("restart_cleared", host_rdata_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
